matrix_operand_loader: RTL
==========================

MATRIX_OPERAND_LOADER -- requirements
Module: matrix_operand_loader

Interface
REQ-001 The block SHALL have parameter ELEM_W, default 4, meaning the width of one matrix element.
REQ-002 The block SHALL have parameter MULT_LATENCY, default 11, meaning the number of clock cycles the downstream Matrix_multiplication needs after start.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the upstream element is valid.
REQ-006 The block SHALL have port in_data, input, ELEM_W bits: one matrix element.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts an element this cycle.
REQ-008 The block SHALL have port flush, input, 1 bit: synchronous discard of a partially loaded operand set.
REQ-009 The block SHALL have port matrix_A, output, 4*ELEM_W bits: packed 2x2 operand A to the multiplier.
REQ-010 The block SHALL have port matrix_B, output, 4*ELEM_W bits: packed 2x2 operand B to the multiplier.
REQ-011 The block SHALL have port start, output, 1 bit: single-cycle launch pulse to the multiplier.
REQ-012 The block SHALL have port busy, output, 1 bit: high while an issued multiply is in flight.
REQ-013 The block SHALL have port issue_count, output, 8 bits: number of multiplies launched, modulo 256.

Function
REQ-014 The block SHALL accept an element only on a cycle where in_valid and in_ready are both 1.
REQ-015 The block SHALL take 8 accepted elements per operand set: elements 0-3 form A and elements 4-7 form B.
REQ-016 Within each operand, the first element SHALL land in bits [4*ELEM_W-1:3*ELEM_W] and the last element in bits [ELEM_W-1:0].
REQ-017 The FSM SHALL have exactly three states: LOAD, ISSUE and WAIT; reset SHALL enter LOAD.
REQ-018 In LOAD, in_ready SHALL be 1 and a 3-bit element index SHALL advance by one per accepted element.
REQ-019 The edge that accepts element 7 SHALL write the final nibble into matrix_B, clear the index, and move the FSM to ISSUE.
REQ-020 In ISSUE, start SHALL be 1 for exactly one cycle, issue_count SHALL increment (255 wraps to 0), and the FSM SHALL go to WAIT.
REQ-021 In WAIT, a down-counter loaded with MULT_LATENCY SHALL decrement once per cycle; when it reaches zero the FSM SHALL return to LOAD.
REQ-022 busy SHALL be 1 in ISSUE and WAIT and 0 in LOAD; in_ready SHALL be 0 whenever busy is 1.
REQ-023 matrix_A and matrix_B SHALL remain stable from the ISSUE cycle through the last WAIT cycle.
REQ-024 Minimum start-to-start spacing SHALL be 1 + MULT_LATENCY + 8 cycles, i.e. 20 cycles at the defaults.
REQ-025 A flush in LOAD SHALL clear the element index; elements already written to matrix_A/matrix_B may remain but SHALL be overwritten by the next set.
REQ-026 If flush and an accepted element occur in the same cycle, flush SHALL win and the element SHALL be discarded, including when it is element 7 (no ISSUE).
REQ-027 flush SHALL be ignored in ISSUE and WAIT.
REQ-028 in_valid held high while in_ready is 0 SHALL cause no state change, and in_data SHALL be ignored.

Reset
REQ-029 Asserting reset low SHALL immediately set: FSM to LOAD, index 0, wait counter 0, matrix_A 0, matrix_B 0, start 0, busy 0, issue_count 0 and in_ready 1.
REQ-030 Reset asserted mid-LOAD, mid-ISSUE or mid-WAIT SHALL abandon the operation with no further start pulse.
REQ-031 The first element SHALL be acceptable on the first rising edge after reset deasserts.

Structure
REQ-032 The FSM state encoding, ELEM_W default and MULT_LATENCY default SHALL live in the shared package matrix_pkg.
REQ-033 The block SHALL be a single module with no sub-modules; the wait counter SHALL be an inline counter.

Verification
REQ-034 Scenario 1: stream 4,3,2,1,1,2,3,4 with in_valid held high -> matrix_A=16'h4321, matrix_B=16'h1234, start pulse 1 cycle after the 8th element, issue_count=1.
REQ-035 Scenario 2: after scenario 1, hold in_valid high continuously -> in_ready=0 for exactly 12 cycles (1 ISSUE + 11 WAIT), and no element is accepted during that window.
REQ-036 Scenario 3: stream 9,6,8,0 then F,F,1,A, with one in_valid=0 bubble -> matrix_A=16'h9680, matrix_B=16'hFF1A, exactly one start pulse.
REQ-037 Scenario 4: send 5 elements, pulse flush, then send 6,5,4,3,A,9,8,7 -> matrix_A=16'h6543, matrix_B=16'hA987, one start pulse.
REQ-038 Scenario 5: assert reset in the 5th WAIT cycle -> all outputs are 0 immediately, in_ready=1, and no start pulse follows.
REQ-039 Scenario 6: launch 256 multiplies -> issue_count wraps to 0, and start-to-start spacing is never below 20 cycles.

Source files
------------

// File: rtl/matrix_pkg.sv
// Shared definitions for the matrix operand loader.
//   state_t              : loader FSM states (LOAD, ISSUE, WAIT)
//   DEFAULT_ELEM_W       : default width of one matrix element
//   DEFAULT_MULT_LATENCY : default downstream multiplier latency in cycles
package matrix_pkg;

  localparam int unsigned DEFAULT_ELEM_W       = 4;
  localparam int unsigned DEFAULT_MULT_LATENCY = 11;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

endpackage

// File: rtl/matrix_operand_loader.sv
// Collects eight streamed elements into two packed 2x2 operands (A then B),
// fires a one-cycle start pulse to the downstream multiplier and then holds
// the operands stable while the multiply is in flight.
//   clock       : single clock, rising edge
//   reset       : asynchronous, active-low
//   in_valid    : upstream element valid
//   in_data     : one matrix element
//   in_ready    : element accepted this cycle when in_valid is also high
//   flush       : discard a partially loaded operand set (LOAD only)
//   matrix_A    : operand A, first element in the top slot
//   matrix_B    : operand B, first element in the top slot
//   start       : one-cycle launch pulse
//   busy        : multiply issued and still in flight
//   issue_count : number of launches, modulo 256
module matrix_operand_loader
  import matrix_pkg::*;
#(
  parameter int unsigned ELEM_W       = DEFAULT_ELEM_W,
  parameter int unsigned MULT_LATENCY = DEFAULT_MULT_LATENCY
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [ELEM_W-1:0]   in_data,
  output logic                in_ready,
  input  logic                flush,
  output logic [4*ELEM_W-1:0] matrix_A,
  output logic [4*ELEM_W-1:0] matrix_B,
  output logic                start,
  output logic                busy,
  output logic [7:0]          issue_count
);

  localparam int unsigned CNT_W = (MULT_LATENCY < 2) ? 1 : $clog2(MULT_LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULT_LATENCY);

  state_t           state;
  state_t           state_next;
  logic [2:0]       idx;
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    start      = 1'b0;
    busy       = 1'b0;
    unique case (state)
      LOAD: begin
        in_ready = 1'b1;
        // flush beats a simultaneous final element: no launch
        if (in_valid && !flush && (idx == 3'd7)) begin
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        start      = 1'b1;
        busy       = 1'b1;
        state_next = WAIT;
      end
      WAIT: begin
        busy = 1'b1;
        // counter is about to hit zero on this edge
        if (wait_cnt <= CNT_W'(1)) begin
          state_next = LOAD;
        end
      end
      default: state_next = LOAD;
    endcase
  end

  // Elements arrive in slot order, so shifting each one in from the bottom
  // leaves the first element of an operand in the top slot after four
  // accepts; this is equivalent to indexed slot writes for a complete set.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      idx         <= '0;
      wait_cnt    <= '0;
      matrix_A    <= '0;
      matrix_B    <= '0;
      issue_count <= '0;
    end else begin
      unique case (state)
        LOAD: begin
          if (flush) begin
            idx <= '0;
          end else if (in_valid) begin
            if (!idx[2]) begin
              matrix_A <= {matrix_A[3*ELEM_W-1:0], in_data};
            end else begin
              matrix_B <= {matrix_B[3*ELEM_W-1:0], in_data};
            end
            idx <= idx + 3'd1; // 7 wraps to 0 as the set completes
          end
        end
        ISSUE: begin
          issue_count <= issue_count + 8'd1;
          wait_cnt    <= CNT_LOAD;
        end
        WAIT: begin
          wait_cnt <= wait_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
